// File: rtl/canvas_store.sv
// 32x32 one-bit drawing canvas with brush stamping, full clear sweep,
// running set-pixel count and a registered read port that freezes updates.
module canvas_store (
    input  logic        clk,
    input  logic        rst,
    input  logic        draw_valid,
    output logic        draw_ready,
    input  logic [4:0]  draw_x,
    input  logic [4:0]  draw_y,
    input  logic        draw_erase,
    input  logic        brush_big,
    input  logic        clear_req,
    input  logic        read_enable,
    input  logic [9:0]  read_addr,
    output logic        read_data,
    output logic [10:0] pixel_count,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] STAMP = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

    logic        r_mem [0:1023];
    logic [1:0]  r_state;
    logic [9:0]  r_addr;
    logic [3:0]  r_step;
    logic [4:0]  r_x;
    logic [4:0]  r_y;
    logic        r_erase;
    logic        r_big;
    logic        r_clear_pending;
    logic [10:0] r_count;
    logic        r_rdata;

    logic [1:0]  w_dxi;
    logic [1:0]  w_dyi;
    logic [5:0]  w_px;
    logic [5:0]  w_py;
    logic        w_in_bounds;
    logic        w_last;
    logic        w_we;
    logic [9:0]  w_waddr;
    logic        w_wdata;
    logic        w_old;

    // Step index 0..8 walks the 3x3 stamp, rows outer; small brush uses step 4 only
    always_comb begin
        w_dyi = 2'd0;
        w_dxi = 2'd0;
        case (r_step)
            4'd0: begin w_dyi = 2'd0; w_dxi = 2'd0; end
            4'd1: begin w_dyi = 2'd0; w_dxi = 2'd1; end
            4'd2: begin w_dyi = 2'd0; w_dxi = 2'd2; end
            4'd3: begin w_dyi = 2'd1; w_dxi = 2'd0; end
            4'd4: begin w_dyi = 2'd1; w_dxi = 2'd1; end
            4'd5: begin w_dyi = 2'd1; w_dxi = 2'd2; end
            4'd6: begin w_dyi = 2'd2; w_dxi = 2'd0; end
            4'd7: begin w_dyi = 2'd2; w_dxi = 2'd1; end
            4'd8: begin w_dyi = 2'd2; w_dxi = 2'd2; end
            default: begin w_dyi = 2'd1; w_dxi = 2'd1; end
        endcase
    end

    // Off-canvas cells land on 32 or 63, both flagged by bit 5
    assign w_px        = {1'b0, r_x} + {4'd0, w_dxi} - 6'd1;
    assign w_py        = {1'b0, r_y} + {4'd0, w_dyi} - 6'd1;
    assign w_in_bounds = !w_px[5] && !w_py[5];
    assign w_last      = (r_step == 4'd8) || !r_big;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_addr;
        w_wdata = 1'b0;
        if (r_state == STAMP) begin
            w_we    = w_in_bounds && !read_enable;
            w_waddr = {w_py[4:0], w_px[4:0]};
            w_wdata = !r_erase;
        end else if (r_state == CLEAR) begin
            w_we    = !read_enable;
            w_waddr = r_addr;
            w_wdata = 1'b0;
        end
    end

    assign w_old = r_mem[w_waddr];

    always_ff @(posedge clk) begin
        if (!rst && w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= CLEAR;
            r_addr          <= 10'd0;
            r_step          <= 4'd0;
            r_x             <= 5'd0;
            r_y             <= 5'd0;
            r_erase         <= 1'b0;
            r_big           <= 1'b0;
            r_clear_pending <= 1'b0;
            r_count         <= 11'd0;
            r_rdata         <= 1'b0;
        end else begin
            r_rdata <= read_enable ? r_mem[read_addr] : 1'b0;
            case (r_state)
                IDLE: begin
                    if (clear_req || r_clear_pending) begin
                        r_state         <= CLEAR;
                        r_addr          <= 10'd0;
                        r_clear_pending <= 1'b0;
                    end else if (draw_valid && draw_ready) begin
                        r_x     <= draw_x;
                        r_y     <= draw_y;
                        r_erase <= draw_erase;
                        r_big   <= brush_big;
                        r_step  <= brush_big ? 4'd0 : 4'd4;
                        r_state <= STAMP;
                    end
                end
                STAMP: begin
                    if (clear_req)
                        r_clear_pending <= 1'b1;
                    if (!read_enable) begin
                        if (w_we && (w_old != w_wdata))
                            r_count <= w_wdata ? r_count + 11'd1
                                               : r_count - 11'd1;
                        if (w_last) begin
                            r_addr <= 10'd0;
                            if (r_clear_pending || clear_req) begin
                                r_state         <= CLEAR;
                                r_clear_pending <= 1'b0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_step <= r_step + 4'd1;
                        end
                    end
                end
                CLEAR: begin
                    r_count <= 11'd0;
                    if (!read_enable) begin
                        if (r_addr == 10'd1023)
                            r_state <= IDLE;
                        r_addr <= r_addr + 10'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign draw_ready  = (r_state == IDLE) && !read_enable && !clear_req
                         && !r_clear_pending;
    assign busy        = (r_state != IDLE);
    assign read_data   = r_rdata;
    assign pixel_count = r_count;

endmodule

// File: tb/tb_canvas_store.sv
// Directed bench for canvas_store: reset sweep, stamps, clipping,
// read stalls, clear arbitration and reset mid-operation.
module tb_canvas_store;

    logic        clk = 1'b0;
    logic        rst;
    logic        draw_valid;
    logic        draw_ready;
    logic [4:0]  draw_x;
    logic [4:0]  draw_y;
    logic        draw_erase;
    logic        brush_big;
    logic        clear_req;
    logic        read_enable;
    logic [9:0]  read_addr;
    logic        read_data;
    logic [10:0] pixel_count;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    canvas_store dut (
        .clk         (clk),
        .rst         (rst),
        .draw_valid  (draw_valid),
        .draw_ready  (draw_ready),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_erase  (draw_erase),
        .brush_big   (brush_big),
        .clear_req   (clear_req),
        .read_enable (read_enable),
        .read_addr   (read_addr),
        .read_data   (read_data),
        .pixel_count (pixel_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, output int d);
        read_enable = 1'b1;
        read_addr   = 10'(a);
        tick();
        d           = int'(read_data);
        read_enable = 1'b0;
    endtask

    task automatic scan(output int ones);
        int d;
        ones = 0;
        for (int a = 0; a < 1024; a++) begin
            rd(a, d);
            ones += d;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic draw(input int x, input int y, input bit erase, input bit big);
        int n;
        n = 0;
        while (!draw_ready && n < 3000) begin
            tick();
            n++;
        end
        check("draw_ready_before_draw", int'(draw_ready), 1);
        draw_x     = 5'(x);
        draw_y     = 5'(y);
        draw_erase = erase;
        brush_big  = big;
        draw_valid = 1'b1;
        tick();
        draw_valid = 1'b0;
    endtask

    task automatic do_clear();
        int n;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_idle(n);
        check("clear_cycles", n, 1024);
    endtask

    int n;
    int d;
    int ones;
    int addrs55 [9] = '{132, 133, 134, 164, 165, 166, 196, 197, 198};

    initial begin
        rst         = 1'b1;
        draw_valid  = 1'b0;
        draw_x      = 5'd0;
        draw_y      = 5'd0;
        draw_erase  = 1'b0;
        brush_big   = 1'b0;
        clear_req   = 1'b0;
        read_enable = 1'b0;
        read_addr   = 10'd0;
        tick();
        tick();
        check("rst_busy", int'(busy), 1);
        check("rst_ready", int'(draw_ready), 0);
        check("rst_count", int'(pixel_count), 0);
        check("rst_rdata", int'(read_data), 0);
        rst = 1'b0;
        wait_idle(n);
        check("reset_sweep_cycles", n, 1024);
        check("post_reset_ready", int'(draw_ready), 1);
        check("post_reset_count", int'(pixel_count), 0);
        scan(ones);
        check("post_reset_scan", ones, 0);

        rd(0, d);
        tick();
        check("rdata_zero_after_strobe", int'(read_data), 0);

        // Big brush in the open
        draw(5, 5, 1'b0, 1'b1);
        wait_idle(n);
        check("big_busy_cycles", n, 9);
        check("big_count", int'(pixel_count), 9);
        for (int i = 0; i < 9; i++) begin
            rd(addrs55[i], d);
            check($sformatf("big_px_%0d", addrs55[i]), d, 1);
        end
        scan(ones);
        check("big_scan", ones, 9);
        do_clear();
        check("clear_count", int'(pixel_count), 0);

        // Corner clipping, no wrap
        draw(0, 31, 1'b0, 1'b1);
        wait_idle(n);
        check("corner_busy_cycles", n, 9);
        check("corner_count", int'(pixel_count), 4);
        rd(960, d); check("corner_960", d, 1);
        rd(961, d); check("corner_961", d, 1);
        rd(992, d); check("corner_992", d, 1);
        rd(993, d); check("corner_993", d, 1);
        rd(1023, d); check("corner_nowrap_1023", d, 0);
        rd(0, d); check("corner_nowrap_0", d, 0);
        scan(ones);
        check("corner_scan", ones, 4);
        do_clear();

        // Count tracking with erase / redundant draw
        draw(5, 5, 1'b0, 1'b1);
        wait_idle(n);
        check("seq_count_a", int'(pixel_count), 9);
        draw(5, 5, 1'b1, 1'b0);
        wait_idle(n);
        check("small_busy_cycles", n, 1);
        check("seq_count_b", int'(pixel_count), 8);
        rd(165, d); check("erased_165", d, 0);
        draw(5, 5, 1'b0, 1'b0);
        wait_idle(n);
        check("seq_count_c", int'(pixel_count), 9);
        draw(5, 5, 1'b0, 1'b0);
        wait_idle(n);
        check("seq_count_d", int'(pixel_count), 9);
        do_clear();

        // Read stall at step 3
        draw(5, 5, 1'b0, 1'b1);
        tick(); tick(); tick();
        read_enable = 1'b1;
        read_addr   = 10'd197;
        for (int i = 0; i < 20; i++) tick();
        check("stall_busy", int'(busy), 1);
        check("stall_count", int'(pixel_count), 3);
        check("stall_no_write_197", int'(read_data), 0);
        read_addr = 10'd132;
        tick();
        check("stall_read_132", int'(read_data), 1);
        check("stall_count_held", int'(pixel_count), 3);
        read_enable = 1'b0;
        wait_idle(n);
        check("stall_remaining_cycles", n, 6);
        check("stall_final_count", int'(pixel_count), 9);
        scan(ones);
        check("stall_scan", ones, 9);
        do_clear();

        // Clear request mid-stamp
        draw(10, 10, 1'b0, 1'b1);
        tick(); tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("pending_blocks_ready", int'(draw_ready), 0);
        wait_idle(n);
        check("stamp_then_clear_cycles", n, 1030);
        check("stamp_then_clear_count", int'(pixel_count), 0);
        rd(330, d); check("stamp_then_clear_330", d, 0);

        // Clear and draw together: clear wins
        draw_x     = 5'd3;
        draw_y     = 5'd3;
        draw_erase = 1'b0;
        brush_big  = 1'b1;
        draw_valid = 1'b1;
        clear_req  = 1'b1;
        #1;
        check("collide_ready", int'(draw_ready), 0);
        tick();
        draw_valid = 1'b0;
        clear_req  = 1'b0;
        wait_idle(n);
        check("collide_clear_cycles", n, 1024);
        check("collide_count", int'(pixel_count), 0);
        scan(ones);
        check("collide_scan", ones, 0);

        // Clear request during read strobe is not lost
        draw(1, 1, 1'b0, 1'b0);
        wait_idle(n);
        check("small_draw_count", int'(pixel_count), 1);
        read_enable = 1'b1;
        read_addr   = 10'd33;
        clear_req   = 1'b1;
        tick();
        clear_req = 1'b0;
        tick(); tick(); tick();
        check("read_clear_busy", int'(busy), 1);
        read_enable = 1'b0;
        wait_idle(n);
        check("read_clear_done", int'(busy), 0);
        check("read_clear_count", int'(pixel_count), 0);
        rd(33, d); check("read_clear_33", d, 0);

        // Reset mid-stamp restarts the sweep
        draw(5, 5, 1'b0, 1'b1);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_count", int'(pixel_count), 0);
        check("midrst_ready", int'(draw_ready), 0);
        rst = 1'b0;
        wait_idle(n);
        check("midrst_sweep_cycles", n, 1024);
        scan(ones);
        check("midrst_scan", ones, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
